// File: rtl/fact_mmio_master_if.sv
// Client request/response handshakes plus the 4-word MMIO bus to the factorial unit.
// The master modport is the sequencer; the slave modport is whatever sits on the other side.
interface fact_mmio_master_if;
  localparam int unsigned N_W    = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  logic              req_valid;
  logic [N_W-1:0]    req_n;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_result;
  logic              resp_error;
  logic              resp_timeout;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [N_W-1:0]    bus_wd;
  logic [DATA_W-1:0] bus_rd;

  modport master (
    input  req_valid, req_n, resp_ready, bus_rd,
    output req_ready, resp_valid, resp_result, resp_error, resp_timeout,
           bus_addr, bus_we, bus_wd
  );

  modport slave (
    output req_valid, req_n, resp_ready, bus_rd,
    input  req_ready, resp_valid, resp_result, resp_error, resp_timeout,
           bus_addr, bus_we, bus_wd
  );
endinterface

// File: rtl/fact_mmio_master.sv
// Sequences write N, write GO, poll STATUS, read RESULT on the factorial unit's register bus
// for one client request at a time, and returns the product or an error/timeout response.
module fact_mmio_master #(
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  fact_mmio_master_if.master   mmio
);

  localparam int unsigned N_W    = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0] LAST_POLL = CNT_W'(POLL_LIMIT - 1);

  localparam logic [ADDR_W-1:0] A_N      = 2'd0;
  localparam logic [ADDR_W-1:0] A_GO     = 2'd1;
  localparam logic [ADDR_W-1:0] A_STATUS = 2'd2;
  localparam logic [ADDR_W-1:0] A_RESULT = 2'd3;

  typedef enum logic [2:0] {IDLE, WR_N, WR_GO, POLL, RD_RES, RESP} state_t;

  state_t             state, state_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               err_q, err_d;
  logic               to_q, to_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic [N_W-1:0]     wd_q, wd_d;

  // State and every output come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      n_q          <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      to_q         <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wd_q         <= '0;
    end else begin
      state        <= state_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      err_q        <= err_d;
      to_q         <= to_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wd_q         <= wd_d;
    end
  end

  // Next state, then outputs decoded from the state being entered so they line up with it.
  always_comb begin
    state_d      = state;
    n_d          = n_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    err_d        = err_q;
    to_d         = to_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    addr_d       = '0;
    we_d         = 1'b0;
    wd_d         = '0;

    case (state)
      IDLE: begin
        if (mmio.req_valid && req_ready_q) begin
          n_d     = mmio.req_n;
          cnt_d   = '0;
          state_d = WR_N;
        end
      end
      WR_N:  state_d = WR_GO;
      WR_GO: state_d = POLL;
      POLL: begin
        // err outranks done when both appear in the same sample
        if (mmio.bus_rd[1]) begin
          err_d    = 1'b1;
          to_d     = 1'b0;
          result_d = '0;
          state_d  = RESP;
        end else if (mmio.bus_rd[0]) begin
          state_d = RD_RES;
        end else if (cnt_q == LAST_POLL) begin
          err_d    = 1'b1;
          to_d     = 1'b1;
          result_d = '0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_RES: begin
        result_d = mmio.bus_rd;
        err_d    = 1'b0;
        to_d     = 1'b0;
        state_d  = RESP;
      end
      RESP: begin
        if (mmio.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      IDLE:   req_ready_d = 1'b1;
      WR_N: begin
        addr_d = A_N;
        we_d   = 1'b1;
        wd_d   = n_d;
      end
      WR_GO: begin
        addr_d = A_GO;
        we_d   = 1'b1;
        wd_d   = N_W'(1);
      end
      POLL:   addr_d = A_STATUS;
      RD_RES: addr_d = A_RESULT;
      RESP:   resp_valid_d = 1'b1;
      default: ;
    endcase
  end

  assign mmio.req_ready    = req_ready_q;
  assign mmio.resp_valid   = resp_valid_q;
  assign mmio.resp_result  = result_q;
  assign mmio.resp_error   = err_q;
  assign mmio.resp_timeout = to_q;
  assign mmio.bus_addr     = addr_q;
  assign mmio.bus_we       = we_q;
  assign mmio.bus_wd       = wd_q;

endmodule

// File: tb/tb_fact_mmio_master.sv
// Bench for fact_mmio_master: a behavioural factorial register slave drives dut_a through a
// vector table and corner sequences; dut_b (POLL_LIMIT=8) faces a slave that never finishes.
module tb_fact_mmio_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fact_mmio_master_if ifa();
  fact_mmio_master_if ifb();

  fact_mmio_master dut_a (.clk(clk), .rst(rst), .mmio(ifa.master));
  fact_mmio_master #(.POLL_LIMIT(8)) dut_b (.clk(clk), .rst(rst), .mmio(ifb.master));

  int checks   = 0;
  int failures = 0;

  // Factorial register slave: N at 0, GO at 1 restarts a job of s_lat cycles, STATUS at 2, RESULT at 3.
  logic [3:0]  s_n    = 4'd0;
  logic        s_done = 1'b0;
  logic        s_err  = 1'b0;
  logic [31:0] s_res  = 32'd0;
  int          s_cnt  = 0;
  int          s_lat  = 1;
  int          s_polls = 0;
  bit          force_mode = 1'b0;

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  always @(posedge clk) begin
    if (ifa.bus_we && ifa.bus_addr == 2'd0) s_n <= ifa.bus_wd;
    if (ifa.bus_we && ifa.bus_addr == 2'd1 && ifa.bus_wd[0]) begin
      s_done  <= 1'b0;
      s_err   <= 1'b0;
      s_cnt   <= s_lat;
      s_polls <= 0;
    end else begin
      if (s_cnt != 0) begin
        s_cnt <= s_cnt - 1;
        if (s_cnt == 1) begin
          if (s_n > 4'd12) s_err <= 1'b1;
          else begin
            s_done <= 1'b1;
            s_res  <= fact(s_n);
          end
        end
      end
      if (!ifa.bus_we && ifa.bus_addr == 2'd2) s_polls <= s_polls + 1;
    end
  end

  always_comb begin
    case (ifa.bus_addr)
      2'd0:    ifa.bus_rd = {28'd0, s_n};
      2'd1:    ifa.bus_rd = 32'd0;
      2'd2:    ifa.bus_rd = (force_mode && s_polls == 2) ? 32'd3 : {30'd0, s_err, s_done};
      default: ifa.bus_rd = s_res;
    endcase
  end

  assign ifb.bus_rd = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  n;
    int          lat;
    int          hold;
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_cycles;
    int          exp_polls;
  } vec_t;

  vec_t vecs[7];

  // Runs one job on dut_a; entered and left at a negedge.
  task automatic run_job(input vec_t v, input string tag);
    int c, polls, rdres, writes, busy_bad, hold_bad;
    bit seen;
    s_lat = v.lat;
    ifa.req_valid = 1'b1;
    ifa.req_n = v.n;
    c = 0;
    while (ifa.req_ready !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) begin
      chk($sformatf("%s_accept", tag), 32'(ifa.req_ready), 32'd1);
      ifa.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    ifa.req_valid = 1'b0;
    c = 1; polls = 0; rdres = 0; writes = 0; busy_bad = 0; hold_bad = 0; seen = 1'b0;
    while (c < 200) begin
      if (ifa.resp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (c == 1)
        chk($sformatf("%s_wr_n", tag), {25'd0, ifa.bus_addr, ifa.bus_we, ifa.bus_wd}, {25'd0, 2'd0, 1'b1, v.n});
      if (c == 2)
        chk($sformatf("%s_wr_go", tag), {25'd0, ifa.bus_addr, ifa.bus_we, ifa.bus_wd}, {25'd0, 2'd1, 1'b1, 4'd1});
      if (ifa.bus_we) writes++;
      if (!ifa.bus_we && ifa.bus_addr == 2'd2) polls++;
      if (!ifa.bus_we && ifa.bus_addr == 2'd3) rdres++;
      if (ifa.req_ready !== 1'b0) busy_bad++;
      @(negedge clk);
      c++;
    end
    chk($sformatf("%s_latency", tag), 32'(c), 32'(v.exp_cycles));
    chk($sformatf("%s_result", tag), ifa.resp_result, v.exp_res);
    chk($sformatf("%s_error", tag), 32'(ifa.resp_error), 32'(v.exp_err));
    chk($sformatf("%s_timeout", tag), 32'(ifa.resp_timeout), 32'd0);
    chk($sformatf("%s_polls", tag), 32'(polls), 32'(v.exp_polls));
    chk($sformatf("%s_rdres", tag), 32'(rdres), v.exp_err ? 32'd0 : 32'd1);
    chk($sformatf("%s_writes", tag), 32'(writes), 32'd2);
    chk($sformatf("%s_busy_ready", tag), 32'(busy_bad), 32'd0);
    if (!seen) return;
    for (int h = 0; h < v.hold; h++) begin
      ifa.req_valid = 1'b1;
      ifa.req_n = 4'd9;
      if (ifa.resp_valid !== 1'b1 || ifa.resp_result !== v.exp_res ||
          ifa.resp_error !== v.exp_err || ifa.req_ready !== 1'b0) hold_bad++;
      @(negedge clk);
    end
    chk($sformatf("%s_hold_stable", tag), 32'(hold_bad), 32'd0);
    ifa.req_valid = 1'b0;
    ifa.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.resp_ready = 1'b0;
    chk($sformatf("%s_post_idle", tag), {29'd0, ifa.req_ready, ifa.resp_valid, ifa.bus_we}, {29'd0, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, polls;
    ifa.req_valid = 1'b0; ifa.req_n = 4'd0; ifa.resp_ready = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_n = 4'd0; ifb.resp_ready = 1'b0;

    //            n      lat hold exp_res          err   cyc polls
    vecs[0] = '{4'd5,  3, 0, 32'd120,        1'b0, 8,  4};
    vecs[1] = '{4'd0,  1, 0, 32'd1,          1'b0, 6,  2};
    vecs[2] = '{4'd1,  1, 0, 32'd1,          1'b0, 6,  2};
    vecs[3] = '{4'd12, 2, 0, 32'd479001600,  1'b0, 7,  3};
    vecs[4] = '{4'd13, 2, 0, 32'd0,          1'b1, 6,  3};
    vecs[5] = '{4'd10, 2, 6, 32'd3628800,    1'b0, 7,  3};
    vecs[6] = '{4'd3,  5, 2, 32'd6,          1'b0, 10, 6};

    // reset values while rst is held low, then req_ready in the first cycle after release
    repeat (3) @(negedge clk);
    chk("rst_a_outputs",
        {24'd0, ifa.req_ready, ifa.resp_valid, ifa.resp_error, ifa.resp_timeout, ifa.bus_addr, ifa.bus_we, 1'b0},
        32'd0);
    chk("rst_a_result", ifa.resp_result, 32'd0);
    chk("rst_a_wd", 32'(ifa.bus_wd), 32'd0);
    chk("rst_b_ready", 32'(ifb.req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'(ifa.req_ready), 32'd1);

    // table: back-to-back jobs, entries 1 and 2 are n=0 then n=1
    for (int i = 0; i < 7; i++) run_job(vecs[i], $sformatf("v%0d", i));

    // done and err together on the 3rd poll: error wins, RESULT never read
    force_mode = 1'b1;
    run_job('{4'd6, 20, 0, 32'd0, 1'b1, 6, 3}, "both_flags");
    force_mode = 1'b0;

    // dut_b: slave never completes, POLL_LIMIT=8
    ifb.req_valid = 1'b1;
    ifb.req_n = 4'd3;
    chk("b_ready", 32'(ifb.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ifb.req_valid = 1'b0;
    c = 1; polls = 0;
    while (ifb.resp_valid !== 1'b1 && c < 100) begin
      if (!ifb.bus_we && ifb.bus_addr == 2'd2) polls++;
      @(negedge clk);
      c++;
    end
    chk("b_latency", 32'(c), 32'd11);
    chk("b_polls", 32'(polls), 32'd8);
    chk("b_flags", {30'd0, ifb.resp_error, ifb.resp_timeout}, 32'd3);
    chk("b_result", ifb.resp_result, 32'd0);
    ifb.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifb.resp_ready = 1'b0;
    chk("b_post_idle", {30'd0, ifb.req_ready, ifb.resp_valid}, 32'd2);

    // reset pulse during the 2nd POLL cycle of n=7
    s_lat = 30;
    ifa.req_valid = 1'b1;
    ifa.req_n = 4'd7;
    @(posedge clk);
    @(negedge clk);
    ifa.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("midpoll_addr", {30'd0, ifa.bus_addr}, 32'd2);
    rst = 1'b0;
    @(negedge clk);
    chk("midpoll_rst_outputs",
        {24'd0, ifa.req_ready, ifa.resp_valid, ifa.resp_error, ifa.resp_timeout, ifa.bus_addr, ifa.bus_we, 1'b0},
        32'd0);
    chk("midpoll_rst_wd", 32'(ifa.bus_wd), 32'd0);
    chk("midpoll_rst_result", ifa.resp_result, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midpoll_idle", {30'd0, ifa.req_ready, ifa.bus_we}, 32'd2);
    run_job('{4'd4, 2, 0, 32'd24, 1'b0, 7, 3}, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fact_mmio_master.md
# fact_mmio_master

Sequencing bus master that drives the factorial unit's 4-word memory-mapped register interface on behalf of a simple request/response client. It accepts a 4-bit operand over a valid/ready handshake, then performs the register sequence: write N, write GO, poll STATUS, read RESULT. It returns the 32-bit product, or an error/timeout indication, over a second valid/ready handshake. It sits directly upstream of the factorial wrapper and connects to its `addr`/`we`/`wd`/`rd` port one-to-one.

## Interface
- `POLL_LIMIT`, default 1024: maximum number of STATUS reads before the job is abandoned. Legal range 1..65535.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  client offers an operand.
- `req_n`  in  4  operand n.
- `req_ready`  out  1  block can accept a request.
- `resp_valid`  out  1  response held for the client.
- `resp_ready`  in  1  client consumes the response.
- `resp_result`  out  32  n! on success, 0 on error/timeout.
- `resp_error`  out  1  unit reported error, or timeout.
- `resp_timeout`  out  1  POLL_LIMIT exhausted (implies `resp_error`).
- `bus_addr`  out  2  register address: 0=N, 1=GO, 2=STATUS {bit1 err, bit0 done}, 3=RESULT.
- `bus_we`  out  1  write strobe.
- `bus_wd`  out  4  write data.
- `bus_rd`  in  32  read data. Combinational from the slave: valid in the same cycle `bus_addr` is presented.

## Operation
- FSM states: IDLE, WR_N, WR_GO, POLL, RD_RES, RESP. All bus outputs are registered-state decodes; no combinational path from `bus_rd` to any bus output.
- IDLE
  - `req_ready`=1; bus idle (`bus_addr`=0, `bus_we`=0, `bus_wd`=0).
  - On `req_valid`: latch `req_n`, clear the poll counter, go to WR_N.
- WR_N: `bus_addr`=0, `bus_we`=1, `bus_wd`=n; go to WR_GO.
- WR_GO: `bus_addr`=1, `bus_we`=1, `bus_wd`=4'b0001; go to POLL. The slave clears its sticky done/err on this write.
- POLL: `bus_addr`=2, `bus_we`=0; sample `bus_rd[1:0]` every cycle. Checks are prioritised in this order:
  1. `bus_rd[1]`=1: latch error=1, result=0; go to RESP.
  2. Else `bus_rd[0]`=1: go to RD_RES.
  3. Else counter==POLL_LIMIT-1: latch error=1, timeout=1, result=0; go to RESP.
  4. Otherwise: counter+1, stay in POLL.
- RD_RES: `bus_addr`=3, `bus_we`=0; latch `bus_rd` into the result register, error=0, timeout=0; go to RESP.
- RESP
  - `resp_valid`=1, with `resp_result`/`resp_error`/`resp_timeout` stable from latched registers.
  - On `resp_ready`: go to IDLE.
- `req_ready`=0 in every state other than IDLE. Requests are never queued.
- The operand is passed through unchecked. Range/overflow policing belongs to the factorial unit's err flag.
- Poll counter is 16 bits, unsigned, and never wraps (exit at POLL_LIMIT-1).
- No bus write occurs outside WR_N and WR_GO.

## Timing
- Reset (`rst`=0 at an edge) forces the following regardless of state, including mid-POLL and mid-RESP. Any in-flight job is dropped with no response.
  - State=IDLE.
  - `req_ready`=0 while `rst` is low, 1 in the first cycle after release.
  - `resp_valid`=0, `resp_result`=0, `resp_error`=0, `resp_timeout`=0.
  - `bus_addr`=0, `bus_we`=0, `bus_wd`=0.
  - Poll counter=0.
- Request handshake: accepted on the edge where `req_valid`&`req_ready`.
- After the acceptance edge, cycles proceed as: WR_N = cycle 1, WR_GO = cycle 2, first POLL = cycle 3.
- If done is first seen on the k-th POLL cycle (k≥1): RD_RES is cycle k+3 and `resp_valid` is first high in cycle k+4.
- If err is seen on the k-th POLL cycle: `resp_valid` is first high in cycle k+3.
- Timeout: exactly POLL_LIMIT STATUS reads, then `resp_valid` in the following cycle.
- Response handshake: completes on the edge where `resp_valid`&`resp_ready`. The next cycle is IDLE with `req_ready`=1.
  - Minimum turnaround between back-to-back jobs is one IDLE cycle.
- `resp_valid` and all response data stay stable while `resp_ready`=0, for any number of cycles.
- Done and err both set in the same POLL sample: the error path wins.

## Test plan
- n=5 against the real wrapper, `resp_ready`=1.
  - Bus trace: (0,we,5), (1,we,1), then STATUS reads.
  - `resp_result`=120, `resp_error`=0, `resp_timeout`=0.
  - `resp_valid` exactly k+4 cycles after acceptance.
- n=0 then n=1 back-to-back → results 1 and 1. Second `req_ready` rises one cycle after the first response handshake.
- Slave model returns STATUS=2'b11 on the 3rd poll → `resp_error`=1, `resp_timeout`=0, `resp_result`=0, and no read of address 3.
- POLL_LIMIT=8, slave model never sets done → exactly 8 STATUS reads, then `resp_error`=1, `resp_timeout`=1, `resp_result`=0.
- n=10 with `resp_ready` held low 6 cycles → `resp_valid` and `resp_result`=3628800 stable throughout; `req_ready`=0 and `req_valid` ignored until the handshake.
- `rst` low for 1 cycle during the 2nd POLL cycle of n=7.
  - Next cycle: IDLE, `bus_we`=0, all outputs at reset values.
  - A following n=4 request completes with `resp_result`=24.
